// File: rtl/mem_access_unit.sv
// Data-memory access unit: takes one load/store at a time from the memory
// stage, drives a req/ack bus transaction with a timeout, and returns an
// aligned, extended load result as a single-cycle completion pulse.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   // The wait counter only has to reach TIMEOUT_CYCLES-1 before giving up.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             write_q;
   logic             signed_q;
   logic [1:0]       size_q;
   logic [31:0]      addr_q;
   logic [3:0]       be_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic             err_q;

   logic             req_bad;
   logic [3:0]       lane_be;
   logic [31:0]      lane_wdata;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_data;
   logic             in_idle;
   logic             in_bus;
   logic             in_resp;

   // Decode the incoming request: alignment/size check, lane strobes and replicated store data.
   always_comb begin
      req_bad    = 1'b0;
      lane_be    = 4'b0000;
      lane_wdata = 32'h0;
      case (req_size)
         2'b00: begin
            lane_be    = 4'b0001 << req_addr[1:0];
            lane_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_bad    = req_addr[0];
            lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            req_bad    = (req_addr[1:0] != 2'b00);
            lane_be    = 4'b1111;
            lane_wdata = req_wdata;
         end
         default: begin
            req_bad = 1'b1;
         end
      endcase
   end

   // Select the addressed lane(s) of the bus word and sign- or zero-extend them.
   always_comb begin
      byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_sel  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_data = mem_rdata;
      case (size_q)
         2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
         default: load_data = mem_rdata;
      endcase
   end

   // Request/bus/response sequencing; the request is latched on acceptance so the bus side stays stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= 32'h0;
         be_q     <= 4'b0000;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  write_q  <= req_write;
                  signed_q <= req_signed;
                  size_q   <= req_size;
                  addr_q   <= req_addr;
                  be_q     <= lane_be;
                  wdata_q  <= lane_wdata;
                  rdata_q  <= 32'h0;
                  cnt      <= '0;
                  err_q    <= req_bad;
                  state    <= req_bad ? S_RESP : S_BUS;
               end
            end
            S_BUS: begin
               if (mem_ack) begin
                  rdata_q <= write_q ? 32'h0 : load_data;
                  err_q   <= 1'b0;
                  state   <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  rdata_q <= 32'h0;
                  err_q   <= 1'b1;
                  state   <= S_RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_idle = (state == S_IDLE);
   assign in_bus  = (state == S_BUS);
   assign in_resp = (state == S_RESP);

   // Bus and response outputs are gated by state so they read as zero outside their phase.
   always_comb begin
      req_ready  = in_idle;
      stall      = (in_idle & req_valid) | in_bus;
      mem_req    = in_bus;
      mem_we     = in_bus & write_q;
      mem_addr   = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_be     = in_bus ? be_q : 4'b0000;
      mem_wdata  = in_bus ? wdata_q : 32'h0;
      resp_valid = in_resp;
      resp_err   = in_resp & err_q;
      resp_rdata = in_resp ? rdata_q : 32'h0;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a response scoreboard and a
// bus responder that acks after a per-vector number of wait cycles.
module tb_mem_access_unit;

   localparam int TMO = 4;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   typedef struct {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_wait;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_bus;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          bus;
   } resp_t;

   localparam int NVEC = 17;
   localparam logic [127:0] RESET_STATE = 128'h1 << 105;

   vec_t  vecs [NVEC];
   resp_t sb [$];
   int    vectors;
   int    miscompares;

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs despite the bounded loops.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [127:0] outState();
      return 128'({req_ready, stall, resp_valid, resp_rdata, resp_err,
                   mem_req, mem_we, mem_addr, mem_be, mem_wdata});
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One request, entered just after a rising edge with the unit idle.
   task automatic applyStimulus(input vec_t v);
      int    cycle;
      int    bus;
      bit    done;
      resp_t exp;
      sb.push_back('{v.exp_err, v.exp_rdata, v.exp_lat, v.exp_bus});
      req_valid  = 1'b1;
      req_write  = v.write;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(negedge clk);
      checkOutput("accept_ready_stall", 128'({req_ready, stall}), 128'(2'b11));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5555_AAAA;
      cycle = 1;
      bus   = 0;
      done  = 1'b0;
      while (!done && cycle <= 20) begin
         if (mem_req) begin
            bus++;
            mem_ack   = (v.ack_wait >= 0) && (bus == v.ack_wait + 1);
            mem_rdata = v.rdata;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hA5A5_5A5A;
         end
         @(negedge clk);
         if (mem_req) begin
            checkOutput("bus_fields",
                        128'({stall, mem_we, mem_addr, mem_be, mem_wdata}),
                        128'({1'b1, v.write, v.addr & 32'hFFFF_FFFC, v.exp_be, v.exp_wdata}));
         end
         if (resp_valid) begin
            done = 1'b1;
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL scoreboard_underflow: got response, expected none");
            end else begin
               exp = sb.pop_front();
               checkOutput("resp_err", 128'(resp_err), 128'(exp.err));
               checkOutput("resp_rdata", 128'(resp_rdata), 128'(exp.rdata));
               checkOutput("resp_latency", 128'(cycle), 128'(exp.lat));
               checkOutput("bus_cycles", 128'(bus), 128'(exp.bus));
            end
            checkOutput("resp_quiet", 128'({req_ready, stall, mem_req, mem_be, mem_addr}), 128'(0));
         end
         @(posedge clk);
         #1;
         cycle++;
      end
      mem_ack = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL resp_timeout: got no resp_valid, expected one by cycle %0d", v.exp_lat);
         void'(sb.pop_front());
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      //          wr  size   sgn addr          wdata         rdata         wait be       exp_wdata     err exp_rdata    lat bus
      vecs[0]  = '{1, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0,        2, 1};
      vecs[1]  = '{0, 2'b00, 1, 32'h0000_2001, 32'h0,        32'h1234_80FF, 3, 4'b0010, 32'h0,        0, 32'hFFFF_FF80, 5, 4};
      vecs[2]  = '{0, 2'b01, 0, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 4'b1100, 32'h0,        0, 32'h0000_BEEF, 2, 1};
      vecs[3]  = '{0, 2'b01, 1, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 4'b1100, 32'h0,        0, 32'hFFFF_BEEF, 2, 1};
      vecs[4]  = '{0, 2'b10, 0, 32'h0000_3002, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0,        1, 0};
      vecs[5]  = '{0, 2'b01, 0, 32'h0000_3001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0,        1, 0};
      vecs[6]  = '{0, 2'b11, 0, 32'h0000_4000, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0,        1, 0};
      vecs[7]  = '{0, 2'b10, 0, 32'h0000_5000, 32'h0,        32'h1234_5678, -1, 4'b1111, 32'h0,       1, 32'h0,        5, 4};
      vecs[8]  = '{0, 2'b10, 0, 32'h0000_5004, 32'h0,        32'hCAFE_F00D, 3, 4'b1111, 32'h0,        0, 32'hCAFE_F00D, 5, 4};
      vecs[9]  = '{1, 2'b01, 0, 32'h0000_6002, 32'h1234_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 0, 32'h0,        2, 1};
      vecs[10] = '{1, 2'b10, 0, 32'h0000_6000, 32'h1122_3344, 32'hFFFF_FFFF, 1, 4'b1111, 32'h1122_3344, 0, 32'h0,       3, 2};
      vecs[11] = '{0, 2'b00, 0, 32'h0000_7003, 32'h0,        32'h80FF_00AA, 2, 4'b1000, 32'h0,        0, 32'h0000_0080, 4, 3};
      vecs[12] = '{0, 2'b00, 1, 32'h0000_7000, 32'h0,        32'h0000_007F, 0, 4'b0001, 32'h0,        0, 32'h0000_007F, 2, 1};
      vecs[13] = '{0, 2'b10, 1, 32'h0000_8000, 32'h0,        32'h8000_0001, 1, 4'b1111, 32'h0,        0, 32'h8000_0001, 3, 2};
      vecs[14] = '{1, 2'b00, 0, 32'h0000_9000, 32'hFFFF_FF5A, 32'h0,        0, 4'b0001, 32'h5A5A_5A5A, 0, 32'h0,        2, 1};
      vecs[15] = '{0, 2'b01, 1, 32'h0000_4000, 32'h0,        32'h7FFF_8001, 0, 4'b0011, 32'h0,        0, 32'hFFFF_8001, 2, 1};
      vecs[16] = '{1, 2'b01, 0, 32'h0000_6001, 32'h0000_FFFF, 32'h0,        0, 4'b0000, 32'h0,        1, 32'h0,        1, 0};

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'h0;
      #12;
      checkOutput("reset_outputs", outState(), RESET_STATE);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
      end

      // Reset in the middle of a bus access abandons it without a response.
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_addr   = 32'h0000_5000;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_mem_req", 128'(mem_req), 128'(1));
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs", outState(), RESET_STATE);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("reset_no_resp", 128'({resp_valid, mem_req}), 128'(0));
      end
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checkOutput("stale_ack_idle", 128'({req_ready, resp_valid, mem_req}), 128'(3'b100));
      @(posedge clk);
      #1;
      checkOutput("stale_ack_no_resp", 128'({resp_valid, resp_err}), 128'(0));
      mem_ack = 1'b0;
      applyStimulus(vecs[2]);
      applyStimulus(vecs[0]);

      checkOutput("scoreboard_empty", 128'(sb.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
